// File: rtl/dmx_tx_engine_if.sv
// Control/write bus and line outputs of the DMX512 transmitter.
// The master side writes slots and requests frames; the slave side drives the line.
interface dmx_tx_engine_if #(
    parameter int ADDR_W = 4
);
    logic              enable;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              dmx_tx;
    logic              dmx_gate;
    logic              frame_start;
    logic              busy;

    modport master (
        output enable, wr_en, wr_addr, wr_data,
        input  dmx_tx, dmx_gate, frame_start, busy
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data,
        output dmx_tx, dmx_gate, frame_start, busy
    );
endinterface

// File: rtl/dmx_tx_engine.sv
// DMX512 frame generator: break, mark-after-break, start code and N_SLOTS data slots
// (8N2, LSB first) from an internal slot buffer, with continuous refresh while enabled.
module dmx_tx_engine #(
    parameter int CLK_HZ     = 12000000,
    parameter int N_SLOTS    = 16,
    parameter int BIT_CLKS   = CLK_HZ / 250000,
    parameter int BREAK_CLKS = 1200,
    parameter int MAB_CLKS   = 144,
    parameter int ADDR_W     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input logic                 i_clk12,
    input logic                 i_rst,
    dmx_tx_engine_if.slave      io_bus
);

    localparam int IDX_W    = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int SLOT_W   = $clog2(N_SLOTS + 1);
    localparam int MAX_A    = (BREAK_CLKS > MAB_CLKS) ? BREAK_CLKS : MAB_CLKS;
    localparam int MAX_CLKS = (MAX_A > BIT_CLKS) ? MAX_A : BIT_CLKS;
    localparam int PH_W     = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;

    localparam logic [PH_W-1:0]   BREAK_LAST = PH_W'(BREAK_CLKS - 1);
    localparam logic [PH_W-1:0]   MAB_LAST   = PH_W'(MAB_CLKS - 1);
    localparam logic [PH_W-1:0]   BIT_LAST   = PH_W'(BIT_CLKS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(N_SLOTS);
    localparam logic [ADDR_W:0]   N_SLOTS_A  = (ADDR_W + 1)'(N_SLOTS);

    typedef enum logic [1:0] {S_IDLE, S_BREAK, S_MAB, S_SLOT} state_t;

    state_t            r_state, w_nxt_state;
    logic [PH_W-1:0]   r_phase, w_nxt_phase;
    logic [3:0]        r_bit,   w_nxt_bit;
    logic [SLOT_W-1:0] r_slot,  w_nxt_slot;
    logic [7:0]        r_buf [N_SLOTS];
    logic [7:0]        r_byte;
    logic [7:0]        w_slot_val;
    logic              w_tx_nxt;
    logic              w_wr_ok;
    logic              r_tx, r_gate, r_fs, r_busy;

    assign w_wr_ok = io_bus.wr_en && ({1'b0, io_bus.wr_addr} < N_SLOTS_A);

    always_ff @(posedge i_clk12) begin
        if (i_rst) begin
            for (int i = 0; i < N_SLOTS; i++) r_buf[i] <= 8'h00;
        end else if (w_wr_ok) begin
            r_buf[IDX_W'(io_bus.wr_addr)] <= io_bus.wr_data;
        end
    end

    // Slot 0 is the start code; slot k carries buffer entry k-1.
    always_comb begin
        w_slot_val = 8'h00;
        if (r_slot != '0) w_slot_val = r_buf[IDX_W'(r_slot - SLOT_W'(1))];
    end

    // Latching at the end of the first start-bit cycle makes a same-cycle write land next frame.
    always_ff @(posedge i_clk12) begin
        if (r_state == S_SLOT && r_phase == '0 && r_bit == 4'd0) r_byte <= w_slot_val;
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_bit   = r_bit;
        w_nxt_slot  = r_slot;
        case (r_state)
            S_IDLE: begin
                if (io_bus.enable) begin
                    w_nxt_state = S_BREAK;
                    w_nxt_phase = '0;
                end
            end
            S_BREAK: begin
                if (r_phase == BREAK_LAST) begin
                    w_nxt_state = S_MAB;
                    w_nxt_phase = '0;
                end else begin
                    w_nxt_phase = r_phase + PH_W'(1);
                end
            end
            S_MAB: begin
                if (r_phase == MAB_LAST) begin
                    w_nxt_state = S_SLOT;
                    w_nxt_phase = '0;
                    w_nxt_bit   = 4'd0;
                    w_nxt_slot  = '0;
                end else begin
                    w_nxt_phase = r_phase + PH_W'(1);
                end
            end
            default: begin
                if (r_phase == BIT_LAST) begin
                    w_nxt_phase = '0;
                    if (r_bit == 4'd10) begin
                        w_nxt_bit = 4'd0;
                        if (r_slot == SLOT_LAST) begin
                            w_nxt_slot  = '0;
                            w_nxt_state = io_bus.enable ? S_BREAK : S_IDLE;
                        end else begin
                            w_nxt_slot = r_slot + SLOT_W'(1);
                        end
                    end else begin
                        w_nxt_bit = r_bit + 4'd1;
                    end
                end else begin
                    w_nxt_phase = r_phase + PH_W'(1);
                end
            end
        endcase

        // Line level for the cycle being entered, so the output register needs no decode.
        w_tx_nxt = 1'b1;
        case (w_nxt_state)
            S_BREAK: w_tx_nxt = 1'b0;
            S_SLOT: begin
                if (w_nxt_bit == 4'd0)      w_tx_nxt = 1'b0;
                else if (w_nxt_bit <= 4'd8) w_tx_nxt = r_byte[3'(w_nxt_bit - 4'd1)];
                else                        w_tx_nxt = 1'b1;
            end
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk12) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_bit   <= 4'd0;
            r_slot  <= '0;
            r_tx    <= 1'b1;
            r_gate  <= 1'b0;
            r_fs    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_phase <= w_nxt_phase;
            r_bit   <= w_nxt_bit;
            r_slot  <= w_nxt_slot;
            r_tx    <= w_tx_nxt;
            r_gate  <= (w_nxt_state != S_IDLE);
            r_busy  <= (w_nxt_state != S_IDLE);
            r_fs    <= (w_nxt_state == S_BREAK) && (r_state != S_BREAK);
        end
    end

    assign io_bus.dmx_tx      = r_tx;
    assign io_bus.dmx_gate    = r_gate;
    assign io_bus.frame_start = r_fs;
    assign io_bus.busy        = r_busy;

endmodule

// File: tb/tb_dmx_tx_engine.sv
// Directed bench for dmx_tx_engine with N_SLOTS=4: frame content and timing, refresh,
// mid-frame disable, same-cycle write at the latch point, and reset mid-break / mid-bit.
module tb_dmx_tx_engine;

    localparam int N_SLOTS    = 4;
    localparam int ADDR_W     = 3;
    localparam int BIT_CLKS   = 48;
    localparam int BREAK_CLKS = 1200;
    localparam int MAB_CLKS   = 144;

    typedef struct {
        logic [31:0] wr_vals;
        logic [31:0] exp_vals;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [3];

    dmx_tx_engine_if #(.ADDR_W(ADDR_W)) bus ();

    dmx_tx_engine #(
        .CLK_HZ    (12000000),
        .N_SLOTS   (N_SLOTS),
        .BIT_CLKS  (BIT_CLKS),
        .BREAK_CLKS(BREAK_CLKS),
        .MAB_CLKS  (MAB_CLKS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .i_clk12(clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle"},
            32'({bus.dmx_tx, bus.dmx_gate, bus.busy, bus.frame_start}), 32'(4'b1000));
    endtask

    task automatic wr(input int addr, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(addr);
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Entered on the negedge of the first break cycle; leaves on the cycle after the last stop bit.
    task automatic check_frame(input logic [31:0] exp, input int drop_slot, input string tag);
        logic        ok;
        logic [10:0] got;
        logic [10:0] want;
        logic [7:0]  b;
        ok = 1'b1;
        for (int i = 0; i < BREAK_CLKS; i++) begin
            if (bus.dmx_tx !== 1'b0 || bus.dmx_gate !== 1'b1 || bus.busy !== 1'b1) ok = 1'b0;
            if (i > 0 && bus.frame_start !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_break"}, 32'(ok), 32'(1));
        ok = 1'b1;
        for (int i = 0; i < MAB_CLKS; i++) begin
            if (bus.dmx_tx !== 1'b1 || bus.dmx_gate !== 1'b1 || bus.frame_start !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_mab"}, 32'(ok), 32'(1));
        for (int s = 0; s <= N_SLOTS; s++) begin
            b    = (s == 0) ? 8'h00 : exp[8*(s-1) +: 8];
            want = {2'b11, b, 1'b0};
            ok   = 1'b1;
            got  = '0;
            for (int j = 0; j < 11; j++) begin
                for (int c = 0; c < BIT_CLKS; c++) begin
                    if (s == drop_slot && j == 0 && c == 0) bus.enable = 1'b0;
                    if (bus.dmx_tx !== want[j] || bus.dmx_gate !== 1'b1) ok = 1'b0;
                    if (c == BIT_CLKS / 2) got[j] = bus.dmx_tx;
                    @(negedge clk);
                end
            end
            chk($sformatf("%s_slot%0d", tag, s), 32'({ok, got}), 32'({1'b1, want}));
        end
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = 8'h00;

        vecs[0] = '{wr_vals: 32'h80FF01A5, exp_vals: 32'h80FF01A5};
        vecs[1] = '{wr_vals: 32'hAA55FF00, exp_vals: 32'hAA55FF00};
        vecs[2] = '{wr_vals: 32'hF00FC33C, exp_vals: 32'hF00FC33C};

        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(bus.dmx_tx),      32'(1));
        chk("rst_gate",  32'(bus.dmx_gate),    32'(0));
        chk("rst_fs",    32'(bus.frame_start), 32'(0));
        chk("rst_busy",  32'(bus.busy),        32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_rst");

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < N_SLOTS; i++) wr(i, vecs[v].wr_vals[8*i +: 8]);
            bus.enable = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_start", v), 32'(bus.frame_start), 32'(1));
            check_frame(vecs[v].exp_vals, -1, $sformatf("v%0d_f1", v));
            chk($sformatf("v%0d_refresh", v), 32'({bus.frame_start, bus.dmx_tx}), 32'(2'b10));
            check_frame(vecs[v].exp_vals, 2, $sformatf("v%0d_f2", v));
            chk_idle($sformatf("v%0d_end", v));
        end

        // Write to buffer[1] exactly in slot 2's latch cycle, then an out-of-range write.
        wr(0, 8'hA5); wr(1, 8'h01); wr(2, 8'hFF); wr(3, 8'h80);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("latch_start", 32'(bus.frame_start), 32'(1));
        fork
            check_frame(32'h80FF01A5, -1, "latch_f1");
            begin
                repeat (BREAK_CLKS + MAB_CLKS + 2 * 11 * BIT_CLKS) @(negedge clk);
                bus.wr_en   = 1'b1;
                bus.wr_addr = 3'd1;
                bus.wr_data = 8'h3C;
                @(negedge clk);
                bus.wr_addr = 3'd7;
                bus.wr_data = 8'hEE;
                @(negedge clk);
                bus.wr_en   = 1'b0;
            end
        join
        chk("latch_refresh", 32'({bus.frame_start, bus.dmx_tx}), 32'(2'b10));
        check_frame(32'h80FF3CA5, 2, "latch_f2");
        chk_idle("latch_end");

        // Reset during break, with a competing write that must lose.
        bus.enable = 1'b1;
        @(negedge clk);
        chk("rb_start", 32'(bus.frame_start), 32'(1));
        repeat (100) @(negedge clk);
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 8'h77;
        @(negedge clk);
        rst       = 1'b0;
        bus.wr_en = 1'b0;
        chk_idle("rst_break");
        @(negedge clk);
        chk("rb_restart", 32'(bus.frame_start), 32'(1));

        // Reset in the middle of data bit 2 of slot 1.
        repeat (BREAK_CLKS + MAB_CLKS + 11 * BIT_CLKS + 3 * BIT_CLKS + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_bit");
        @(negedge clk);
        chk("rbit_restart", 32'(bus.frame_start), 32'(1));
        check_frame(32'h00000000, 2, "zeroed");
        chk_idle("zeroed_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmx_tx_engine.md
DMX_TX_ENGINE -- requirements
Module: dmx_tx_engine

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter N_SLOTS, default 16, data slots per frame, legal range 1..512.
REQ-003 Parameter BIT_CLKS = CLK_HZ/250000, default 48, clocks per DMX bit (4 us).
REQ-004 Parameter BREAK_CLKS, default 1200 (100 us), line-low break length in clocks; minimum 1056 (88 us).
REQ-005 Parameter MAB_CLKS, default 144 (12 us), mark-after-break length in clocks; minimum 96 (8 us).
REQ-006 Parameter ADDR_W = clog2(N_SLOTS), minimum 1.
REQ-007 CLK12  in  1  sole clock; one clock, all logic on its rising edge.
REQ-008 RST  in  1  reset, synchronous and active-high.
REQ-009 ENABLE  in  1  level; high requests continuous frame transmission.
REQ-010 WR_EN  in  1  slot-buffer write strobe, one write per cycle.
REQ-011 WR_ADDR  in  ADDR_W  slot index, 0 = first data slot.
REQ-012 WR_DATA  in  8  slot value.
REQ-013 DMX_TX  out  1  serial line to RS-485 driver; 1 = mark/idle.
REQ-014 DMX_GATE  out  1  RS-485 driver enable; 1 = drive.
REQ-015 FRAME_START  out  1  one-cycle pulse on the first cycle of each break.
REQ-016 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-017 The block SHALL hold an N_SLOTS x 8 slot buffer; on WR_EN with WR_ADDR < N_SLOTS, WR_DATA is stored at the next edge; writes with WR_ADDR >= N_SLOTS are ignored.
REQ-018 The FSM SHALL have the states IDLE, BREAK, MAB and SLOT.
REQ-019 IDLE: DMX_TX=1, DMX_GATE=0; when ENABLE=1, the next cycle enters BREAK.
REQ-020 BREAK: DMX_TX=0, DMX_GATE=1, held exactly BREAK_CLKS cycles; FRAME_START=1 in the first BREAK cycle only.
REQ-021 MAB: DMX_TX=1, DMX_GATE=1, held exactly MAB_CLKS cycles, then SLOT with slot index 0, which is the start code.
REQ-022 SLOT: each slot is 11 bits of BIT_CLKS cycles each: start bit 0, data bits 0..7 LSB first, and two stop bits 1; DMX_GATE=1.
REQ-023 Slot index 0 SHALL transmit start code 0x00; slot index k (1..N_SLOTS) transmits buffer[k-1].
REQ-024 The slot byte SHALL be latched into the shift register in the first cycle of that slot's start bit.
REQ-025 A write to the same entry in the latch cycle SHALL NOT affect the byte in flight; the old value is sent and the new value is used next frame.
REQ-026 Slots SHALL be back-to-back, with no inter-slot mark.
REQ-027 After the last stop bit of slot N_SLOTS: if ENABLE=1, the next cycle is BREAK (continuous refresh); otherwise the next state is IDLE.
REQ-028 ENABLE SHALL be sampled only in IDLE and at end of frame; deasserting it mid-frame completes the current frame.
REQ-029 Bit and phase counters SHALL count 0..N-1 and reload without drift.
REQ-030 Frame length SHALL be exactly BREAK_CLKS + MAB_CLKS + (N_SLOTS+1)*11*BIT_CLKS cycles.
REQ-031 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-032 RST=1 at an edge SHALL force the following values at that edge, regardless of state or mid-bit/mid-break position:
- state IDLE
- DMX_TX=1, DMX_GATE=0, FRAME_START=0, BUSY=0
- all counters 0
- all slot-buffer entries 0x00
REQ-033 RST SHALL take priority over WR_EN and ENABLE in the same cycle.
REQ-034 After RST deasserts with ENABLE=1, BREAK SHALL begin one cycle later.

Verification (N_SLOTS=4, defaults otherwise)
REQ-035 Write 0xA5,0x01,0xFF,0x80 to slots 0..3, then ENABLE=1 -> expected:
- BREAK low 1200 cycles, MAB high 144
- start code 0x00
- bytes A5,01,FF,80 LSB-first at 48 cycles/bit, with stop bits high
- frame length 1200+144+5*11*48 = 3984 cycles
REQ-036 ENABLE held 1 -> FRAME_START pulses exactly 3984 cycles apart, with no gap between the last stop bit and the next break.
REQ-037 ENABLE dropped during slot 2 -> frame completes through slot 4 stop bits, then IDLE with DMX_TX=1, DMX_GATE=0, BUSY=0.
REQ-038 WR_EN to slot index 2 (buffer[1]) with 0x3C in its start-bit first cycle, while old value is 0x01 -> 0x01 sent this frame and 0x3C next frame; WR_ADDR=7 write ignored.
REQ-039 RST pulsed during BREAK and again mid data bit -> next cycle DMX_TX=1, DMX_GATE=0, and all slots read back as 0x00 in the following frame.
